logic_unit: RTL and testbench

Parametrised, registered bitwise logic unit for the ALU datapath; it supersedes the fixed 16-bit single-function gate blocks. It accepts two operands and a 3-bit opcode over a valid/ready handshake and returns the result one cycle later through a single output register. An internal accumulator can stand in for operand B and can capture results, so chained masks can be built without external storage.

---
 rtl/logic_unit_pkg.sv | 17 +
 rtl/logic_unit_if.sv | 34 +++
 rtl/logic_unit_core.sv | 40 ++++
 rtl/logic_unit.sv | 110 +++++++++++
 tb/tb_logic_unit.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the bitwise logic unit and its combinational core.
package logic_unit_pkg;

  localparam int LU_OP_W = 3;

  typedef enum logic [LU_OP_W-1:0] {
    LU_AND    = 3'd0,
    LU_OR     = 3'd1,
    LU_XOR    = 3'd2,
    LU_NAND   = 3'd3,
    LU_NOR    = 3'd4,
    LU_XNOR   = 3'd5,
    LU_ANDN   = 3'd6,
    LU_PASS_A = 3'd7
  } lu_op_e;

endpackage

// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle for logic_unit; master drives operands, slave is the unit.
interface logic_unit_if
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [LU_OP_W-1:0] in_op;
  logic               in_acc_src;
  logic               in_acc_wr;
  logic               acc_clr;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_res;
  logic               out_zero;
  logic               out_ones;
  logic               out_par;
  logic [WIDTH-1:0]   acc_q;

  modport master (
    output in_valid, in_a, in_b, in_op, in_acc_src, in_acc_wr, acc_clr, out_ready,
    input  in_ready, out_valid, out_res, out_zero, out_ones, out_par, acc_q
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_acc_src, in_acc_wr, acc_clr, out_ready,
    output in_ready, out_valid, out_res, out_zero, out_ones, out_par, acc_q
  );

endinterface

// File: rtl/logic_unit_core.sv
// Combinational f(op, A, B); zero/ones/parity reduction exists only with LOGIC_UNIT_FLAGS_EN.
// Zero latency, no handshake of its own.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [LU_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
`ifdef LOGIC_UNIT_FLAGS_EN
  output logic               zero_o,
  output logic               ones_o,
  output logic               par_o,
`endif
  output logic [WIDTH-1:0]   res_o
);

  always_comb begin
    res_o = '0;
    case (lu_op_e'(op_i))
      LU_AND:    res_o = a_i & b_i;
      LU_OR:     res_o = a_i | b_i;
      LU_XOR:    res_o = a_i ^ b_i;
      LU_NAND:   res_o = ~(a_i & b_i);
      LU_NOR:    res_o = ~(a_i | b_i);
      LU_XNOR:   res_o = ~(a_i ^ b_i);
      LU_ANDN:   res_o = a_i & ~b_i;
      LU_PASS_A: res_o = a_i;
      default:   res_o = '0;
    endcase
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  assign zero_o = ~|res_o;
  assign ones_o = &res_o;
  assign par_o  = ^res_o;
`endif

endmodule

// File: rtl/logic_unit.sv
// Registered bitwise logic unit with accumulator; 1-cycle latency, full throughput, stalls
// via in_ready = ~out_valid | out_ready. Flag registers present only with LOGIC_UNIT_FLAGS_EN.
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  logic_unit_if.slave  bus
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] core_res;
  logic             in_rdy;
  logic             accept;

  assign in_rdy = ~vld_q | bus.out_ready;
  assign accept = bus.in_valid & in_rdy;
  // Pre-update accumulator feeds B, so a same-cycle clear or write is not visible here.
  assign b_eff  = bus.in_acc_src ? acc_q : bus.in_b;

`ifdef LOGIC_UNIT_FLAGS_EN
  logic core_zero, core_ones, core_par;
  logic zero_q, zero_d, ones_q, ones_d, par_q, par_d;
`endif

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op_i   (bus.in_op),
    .a_i    (bus.in_a),
    .b_i    (b_eff),
`ifdef LOGIC_UNIT_FLAGS_EN
    .zero_o (core_zero),
    .ones_o (core_ones),
    .par_o  (core_par),
`endif
    .res_o  (core_res)
  );

  always_comb begin
    vld_d = vld_q;
    res_d = res_q;
    acc_d = acc_q;
    if (accept) begin
      vld_d = 1'b1;
      res_d = core_res;
    end else if (bus.out_ready) begin
      vld_d = 1'b0;
    end
    if (bus.acc_clr) begin
      acc_d = '0;
    end else if (accept && bus.in_acc_wr) begin
      acc_d = core_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      res_q <= '0;
      acc_q <= '0;
    end else begin
      vld_q <= vld_d;
      res_q <= res_d;
      acc_q <= acc_d;
    end
  end

`ifdef LOGIC_UNIT_FLAGS_EN
  always_comb begin
    zero_d = zero_q;
    ones_d = ones_q;
    par_d  = par_q;
    if (accept) begin
      zero_d = core_zero;
      ones_d = core_ones;
      par_d  = core_par;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b1;
      ones_q <= 1'b0;
      par_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      ones_q <= ones_d;
      par_q  <= par_d;
    end
  end

  assign bus.out_zero = zero_q;
  assign bus.out_ones = ones_q;
  assign bus.out_par  = par_q;
`else
  assign bus.out_zero = 1'b0;
  assign bus.out_ones = 1'b0;
  assign bus.out_par  = 1'b0;
`endif

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = vld_q;
  assign bus.out_res   = res_q;
  assign bus.acc_q     = acc_q;

endmodule

// File: tb/tb_logic_unit.sv
// Scoreboard bench for logic_unit: driver pushes expected results, monitor pops on transfer.
// Flag expectations follow LOGIC_UNIT_FLAGS_EN.
module tb_logic_unit;
  import logic_unit_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic_unit_if #(.WIDTH(W)) bus();
  logic_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         o;
    logic         p;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] m_acc;
  bit           m_full;
  bit           mon_en = 1'b0;

  // Each opcode is a 2-input truth table indexed by {a_bit, b_bit}.
  function automatic logic [W-1:0] ref_f(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [3:0]   tt;
    logic [W-1:0] r;
    case (op)
      0: tt = 4'b1000;
      1: tt = 4'b1110;
      2: tt = 4'b0110;
      3: tt = 4'b0111;
      4: tt = 4'b0001;
      5: tt = 4'b1001;
      6: tt = 4'b0100;
      default: tt = 4'b1100;
    endcase
    for (int i = 0; i < W; i++) r[i] = tt[{a[i], b[i]}];
    return r;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] r);
    exp_t e;
    int   ones;
    e.res = r;
    ones = 0;
    for (int i = 0; i < W; i++) ones += int'(r[i]);
`ifdef LOGIC_UNIT_FLAGS_EN
    e.z = (ones == 0);
    e.o = (ones == W);
    e.p = ones[0];
`else
    e.z = 1'b0;
    e.o = 1'b0;
    e.p = 1'b0;
`endif
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; model state advances at the following rising edge.
  task automatic cycle(input bit v, input logic [W-1:0] a, input logic [W-1:0] b, input int op,
                       input bit src, input bit wr, input bit clr, input bit ordy,
                       input bit ovr, input logic [W-1:0] ov, output bit acc);
    logic [W-1:0] r, nxt;
    bit           full_n;
    @(negedge clk);
    bus.in_valid   = v;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_op      = 3'(op);
    bus.in_acc_src = src;
    bus.in_acc_wr  = wr;
    bus.acc_clr    = clr;
    bus.out_ready  = ordy;
    #1;
    chk("in_ready", W'(bus.in_ready), W'(!m_full || ordy));
    chk("out_valid", W'(bus.out_valid), W'(m_full));
    acc = v && bus.in_ready;
    nxt = m_acc;
    if (acc) begin
      r = ovr ? ov : ref_f(op, a, src ? m_acc : b);
      sb.push_back(mk(r));
      if (wr) nxt = r;
    end
    if (clr) nxt = '0;
    full_n = acc ? 1'b1 : (ordy ? 1'b0 : m_full);
    @(posedge clk);
    m_acc  = nxt;
    m_full = full_n;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input int op,
                      input bit src, input bit wr, input bit clr, input bit ovr, input logic [W-1:0] ov);
    bit acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin
      cycle(1'b1, a, b, op, src, wr, clr, 1'b1, ovr, ov, acc);
      n++;
    end
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got not-accepted expected accepted");
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        chk("acc_q", bus.acc_q, m_acc);
        if (bus.out_valid) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_empty: got out_valid=1 expected no pending result");
          end else begin
            e = sb[0];
            chk("out_res", bus.out_res, e.res);
            chk("out_zero", W'(bus.out_zero), W'(e.z));
            chk("out_ones", W'(bus.out_ones), W'(e.o));
            chk("out_par", W'(bus.out_par), W'(e.p));
            if (bus.out_ready) void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] tbl [8];
  bit           acc;
  int           n;

  initial begin : driver
    tbl = '{16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, 16'h000F, 16'hF00F, 16'h00F0, 16'hF0F0};
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0;
    bus.in_acc_src = 0; bus.in_acc_wr = 0; bus.acc_clr = 0; bus.out_ready = 1;
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready_async", W'(bus.in_ready), W'(1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", W'(bus.out_valid), '0);
    chk("rst_acc_q", bus.acc_q, '0);
    chk("rst_out_res", bus.out_res, '0);
    chk("rst_in_ready", W'(bus.in_ready), W'(1));
    chk("rst_out_zero", W'(bus.out_zero), W'(mk('0).z));
    chk("rst_out_ones", W'(bus.out_ones), '0);
    chk("rst_out_par", W'(bus.out_par), '0);
    m_acc = '0;
    m_full = 1'b0;
    mon_en = 1'b1;

    // All opcodes back to back: every beat must be accepted on its own cycle.
    for (int op = 0; op < 8; op++) begin
      cycle(1'b1, 16'hF0F0, 16'hFF00, op, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, tbl[op], acc);
      chk("no_bubble", W'(acc), W'(1));
    end

    // Backpressure: result must hold and the next beat wait for out_ready.
    send(16'h0001, 16'h0002, 1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 16'h0004, 16'h0008, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h000C, acc);
      chk("bp_stall_accept", W'(acc), '0);
    end
    cycle(1'b1, 16'h0004, 16'h0008, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h000C, acc);
    chk("bp_release_accept", W'(acc), W'(1));

    // Accumulator chain.
    cycle(1'b0, '0, '0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, acc);
    send(16'h00FF, 16'hFFFF, 1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00FF);
    send(16'h0F0F, 16'hFFFF, 2, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0FF0);
    #1;
    chk("acc_chain", bus.acc_q, 16'h0FF0);

    // Clear wins over a same-cycle accumulator write.
    send(16'h1234, 16'h0000, 7, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
    send(16'hBEEF, 16'h0000, 7, 1'b0, 1'b1, 1'b1, 1'b1, 16'hBEEF);
    #1;
    chk("clr_vs_wr", bus.acc_q, 16'h0000);

    // Flag patterns.
    send(16'hAAAA, 16'hAAAA, 2, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    send(16'hAAAA, 16'h5555, 1, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    send(16'h0001, 16'h0000, 7, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 500; i++) begin
      cycle(bit'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), int'($urandom_range(0, 7)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 7) == 0),
            bit'($urandom_range(0, 3) != 0), 1'b0, '0, acc);
    end

    n = 0;
    while (m_full && n < 20) begin
      cycle(1'b0, '0, '0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, acc);
      n++;
    end
    @(negedge clk);
    #3;
    chk("sb_drained", W'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
